// File: rtl/plate_pkg.sv
// Shared types and constants for the plate-to-display sequencer.
// Slot count, count width, FSM states and the full-slot mask.
package plate_pkg;

  localparam int CW   = 5;
  localparam int NSEG = 6;

  typedef logic [NSEG-1:0] mask_t;

  localparam mask_t FULL_MASK = 6'b111111;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COLLECT     = 2'd1,
    WAIT_VBLANK = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fall_det.sv
// Registers an active-low sync and flags the cycle it goes low.
// Reusable for hsync or vsync.
module sync_fall_det (
  input  logic dclk,
  input  logic clr,
  input  logic sync,
  output logic sync_q,
  output logic fall
);

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) sync_q <= 1'b1;
    else     sync_q <= sync;
  end

  assign fall = sync_q & ~sync;

endmodule

// File: rtl/plate_frame_ctrl.sv
// Collects one six-slot plate from the recognizer and commits it
// to the display count registers on the vsync falling edge.
import plate_pkg::*;

module plate_frame_ctrl #(
  parameter int CW           = plate_pkg::CW,
  parameter int STALE_FRAMES = 60
) (
  input  logic          dclk,
  input  logic          clr,
  input  logic          vsync,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_idx,
  input  logic [CW-1:0] in_count,
  input  logic          in_last,
  output logic [CW-1:0] seg1count,
  output logic [CW-1:0] seg2count,
  output logic [CW-1:0] seg3count,
  output logic [CW-1:0] seg4count,
  output logic [CW-1:0] seg5count,
  output logic [CW-1:0] seg6count,
  output logic [7:0]    commit_cnt,
  output logic          err_incomplete,
  output logic          err_idx,
  output logic          stale
);

  localparam logic [7:0] STALE_MAX = 8'(STALE_FRAMES);

  state_t          state;
  state_t          state_nx;
  mask_t           mask;
  mask_t           wmask;
  logic [CW-1:0]   shadow [NSEG];
  logic [CW-1:0]   disp   [NSEG];
  logic [7:0]      stale_cnt;
  logic            vsync_q;
  logic            fall;
  logic            acc;
  logic            bad;
  logic            full;
  logic            commit;
  logic            incompl;

  sync_fall_det u_vfall (
    .dclk   (dclk),
    .clr    (clr),
    .sync   (vsync),
    .sync_q (vsync_q),
    .fall   (fall)
  );

  assign acc     = in_valid & in_ready;
  assign bad     = (in_idx > 3'd5);
  assign wmask   = bad ? mask : (mask | (mask_t'(1) << in_idx));
  assign full    = (wmask == FULL_MASK);
  assign incompl = acc & in_last & ~full;
  assign commit  = (state == WAIT_VBLANK) & fall;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, COLLECT: begin
        if (acc) begin
          if (in_last) state_nx = full ? WAIT_VBLANK : IDLE;
          else         state_nx = COLLECT;
        end
      end
      WAIT_VBLANK: begin
        if (fall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    unique case (state)
      WAIT_VBLANK: in_ready = 1'b0;
      default:     in_ready = 1'b1;
    endcase
  end

  // A completed mask stays full until the commit clears it.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      mask <= '0;
    end else if (commit || incompl) begin
      mask <= '0;
    end else if (acc) begin
      mask <= wmask;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NSEG; i++) shadow[i] <= '0;
    end else if (acc && !bad) begin
      shadow[in_idx] <= in_count;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NSEG; i++) disp[i] <= '0;
      commit_cnt <= '0;
    end else if (commit) begin
      for (int i = 0; i < NSEG; i++) disp[i] <= shadow[i];
      commit_cnt <= commit_cnt + 8'd1;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      stale_cnt <= '0;
    end else if (commit) begin
      stale_cnt <= '0;
    end else if (fall && stale_cnt != STALE_MAX) begin
      stale_cnt <= stale_cnt + 8'd1;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      err_incomplete <= 1'b0;
      err_idx        <= 1'b0;
    end else begin
      err_incomplete <= incompl;
      err_idx        <= acc & bad;
    end
  end

  assign stale     = (stale_cnt == STALE_MAX);
  assign seg1count = disp[0];
  assign seg2count = disp[1];
  assign seg3count = disp[2];
  assign seg4count = disp[3];
  assign seg5count = disp[4];
  assign seg6count = disp[5];

endmodule

// File: tb/tb_plate_frame_ctrl.sv
// Directed bench for plate_frame_ctrl with STALE_FRAMES=3.
// Each step checks outputs #1 after the active clock edge.
module tb_plate_frame_ctrl;

  localparam int CW = 5;

  logic          dclk = 1'b0;
  logic          clr = 1'b1;
  logic          vsync = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_idx = '0;
  logic [CW-1:0] in_count = '0;
  logic          in_last = 1'b0;
  logic [CW-1:0] seg1count, seg2count, seg3count;
  logic [CW-1:0] seg4count, seg5count, seg6count;
  logic [7:0]    commit_cnt;
  logic          err_incomplete;
  logic          err_idx;
  logic          stale;

  int vec = 0;
  int bad = 0;

  plate_frame_ctrl #(.CW(CW), .STALE_FRAMES(3)) dut (
    .dclk           (dclk),
    .clr            (clr),
    .vsync          (vsync),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_idx         (in_idx),
    .in_count       (in_count),
    .in_last        (in_last),
    .seg1count      (seg1count),
    .seg2count      (seg2count),
    .seg3count      (seg3count),
    .seg4count      (seg4count),
    .seg5count      (seg5count),
    .seg6count      (seg6count),
    .commit_cnt     (commit_cnt),
    .err_incomplete (err_incomplete),
    .err_idx        (err_idx),
    .stale          (stale)
  );

  always #20 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_segs(input string tag, input int a, input int b,
                          input int c, input int d, input int e,
                          input int f);
    chk({tag, "_s1"}, 32'(seg1count), 32'(a));
    chk({tag, "_s2"}, 32'(seg2count), 32'(b));
    chk({tag, "_s3"}, 32'(seg3count), 32'(c));
    chk({tag, "_s4"}, 32'(seg4count), 32'(d));
    chk({tag, "_s5"}, 32'(seg5count), 32'(e));
    chk({tag, "_s6"}, 32'(seg6count), 32'(f));
  endtask

  task automatic xfer(input int idx, input int cnt, input bit last);
    @(negedge dclk);
    in_valid = 1'b1;
    in_idx   = 3'(idx);
    in_count = CW'(cnt);
    in_last  = last;
    @(posedge dclk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic vlow();
    @(negedge dclk);
    vsync = 1'b0;
    @(posedge dclk);
    #1;
  endtask

  task automatic vhigh();
    @(negedge dclk);
    vsync = 1'b1;
    @(posedge dclk);
    #1;
  endtask

  task automatic idle_cycle();
    @(posedge dclk);
    #1;
  endtask

  initial begin
    #50;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(commit_cnt), 32'd0);
    chk("rst_stale", 32'(stale), 32'd0);
    chk("rst_einc", 32'(err_incomplete), 32'd0);
    chk("rst_eidx", 32'(err_idx), 32'd0);
    chk_segs("rst", 0, 0, 0, 0, 0, 0);
    @(negedge dclk);
    clr = 1'b0;
    idle_cycle();

    // no input: stale on the third falling edge
    vlow(); vhigh();
    vlow(); vhigh();
    chk("stale_2", 32'(stale), 32'd0);
    vlow();
    chk("stale_3", 32'(stale), 32'd1);
    vhigh();

    // first complete plate of nines
    for (int i = 0; i < 6; i++) xfer(i, 9, i == 5);
    chk("p1_ready", 32'(in_ready), 32'd0);
    chk("p1_pre_s1", 32'(seg1count), 32'd0);
    idle_cycle();
    chk("p1_hold_s1", 32'(seg1count), 32'd0);
    vlow();
    chk_segs("p1", 9, 9, 9, 9, 9, 9);
    chk("p1_cnt", 32'(commit_cnt), 32'd1);
    chk("p1_stale", 32'(stale), 32'd0);
    chk("p1_ready2", 32'(in_ready), 32'd1);
    vhigh();

    // slot 3 missing
    xfer(0, 4, 0); xfer(1, 4, 0); xfer(2, 4, 0);
    xfer(4, 4, 0); xfer(5, 4, 1);
    chk("inc_pulse", 32'(err_incomplete), 32'd1);
    chk("inc_ready", 32'(in_ready), 32'd1);
    chk("inc_s1", 32'(seg1count), 32'd9);
    idle_cycle();
    chk("inc_pulse_end", 32'(err_incomplete), 32'd0);
    for (int i = 0; i < 6; i++) xfer(i, i + 1, i == 5);
    chk("p2_ready", 32'(in_ready), 32'd0);
    vlow();
    chk_segs("p2", 1, 2, 3, 4, 5, 6);
    chk("p2_cnt", 32'(commit_cnt), 32'd2);
    vhigh();

    // illegal index, then plate with slot 2 overwritten
    xfer(7, 20, 0);
    chk("eidx_pulse", 32'(err_idx), 32'd1);
    xfer(0, 10, 0);
    chk("eidx_end", 32'(err_idx), 32'd0);
    xfer(1, 11, 0); xfer(2, 3, 0); xfer(3, 13, 0);
    xfer(2, 12, 0); xfer(4, 14, 0); xfer(5, 15, 1);
    chk("p3_einc", 32'(err_incomplete), 32'd0);
    vlow();
    chk_segs("p3", 10, 11, 12, 13, 14, 15);
    chk("p3_cnt", 32'(commit_cnt), 32'd3);
    vhigh();

    // clr while waiting for vblank
    for (int i = 0; i < 6; i++) xfer(i, 31, i == 5);
    chk("clr_pre_ready", 32'(in_ready), 32'd0);
    #5 clr = 1'b1;
    #1;
    chk_segs("clr", 0, 0, 0, 0, 0, 0);
    chk("clr_cnt", 32'(commit_cnt), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    @(negedge dclk);
    clr = 1'b0;
    vlow();
    chk("clr_nocommit", 32'(commit_cnt), 32'd0);
    chk("clr_s1", 32'(seg1count), 32'd0);
    vhigh();

    // last transfer coincides with a vsync fall: no commit
    for (int i = 0; i < 5; i++) xfer(i, 7, 0);
    vsync = 1'b0;
    xfer(5, 8, 1);
    chk("co_ready", 32'(in_ready), 32'd0);
    chk("co_cnt", 32'(commit_cnt), 32'd0);
    chk("co_s6", 32'(seg6count), 32'd0);
    vhigh();
    vlow();
    chk_segs("co", 7, 7, 7, 7, 7, 8);
    chk("co_cnt2", 32'(commit_cnt), 32'd1);
    vhigh();

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
